// File: rtl/custom_types_pkg.sv
// Shared types for the L1 dcache and its snoop responder.
package custom_types_pkg;

  typedef logic [31:0] word_t;

  // Load-linked link register: linked byte address plus a valid flag.
  typedef struct packed {
    word_t addr;
    logic  valid;
  } lr_t;

  localparam int TAG_W = 26;
  localparam int IDX_W = 3;

  // Snoop responder states.
  typedef enum logic [2:0] {
    SNP_IDLE   = 3'd0,
    SNP_LOOKUP = 3'd1,
    SNP_WB1    = 3'd2,
    SNP_WB2    = 3'd3,
    SNP_RESP   = 3'd4,
    SNP_HOLD   = 3'd5
  } snoop_t;

  // One dcache frame carried as a single bus.
  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
    word_t [1:0]      data;
  } dframe_t;

  // True when the link register points into the 8-byte block at base.
  function automatic logic lr_match(input lr_t link, input word_t base);
    return link.valid && (((link.addr ^ base) & 32'hFFFF_FFF8) == 32'h0000_0000);
  endfunction

endpackage

// File: rtl/dcache_snoop_responder.sv
// Snoop responder: looks up the snooped block, supplies it if Modified,
// then downgrades/invalidates the frame and breaks a matching LL link.
module dcache_snoop_responder
  import custom_types_pkg::*;
#(
  parameter int SETS = 8,
  parameter int WAYS = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          ccwait,
  input  logic                          ccinv,
  input  logic [31:0]                   ccsnoopaddr,
  input  logic                          dwait,
  input  logic [WAYS-1:0]               frame_valid,
  input  logic [WAYS-1:0]               frame_dirty,
  input  logic [WAYS-1:0][TAG_W-1:0]    frame_tag,
  input  logic [WAYS-1:0][1:0][31:0]    frame_data,
  input  lr_t                           lr,
  output logic [$clog2(SETS)-1:0]       snp_idx,
  output logic                          snp_busy,
  output logic                          ccwrite,
  output logic                          cctrans,
  output logic                          snp_dWEN,
  output logic [31:0]                   snp_daddr,
  output logic [31:0]                   snp_dstore,
  output logic                          snp_upd,
  output logic                          snp_upd_way,
  output logic                          snp_upd_valid,
  output logic                          snp_upd_dirty,
  output logic                          lr_clear
);

  snoop_t  state_r;
  word_t   addr_r;
  logic    inv_r;
  logic    hit_r;
  logic    way_r;
  logic    hitdirty_r;
  logic    lr_hit_r;
  word_t   word0_r;
  word_t   word1_r;

  dframe_t frame_s [WAYS];
  dframe_t hit_frame_s;
  logic    hit_s;
  logic    way_s;
  logic    hitdirty_s;

  // Frame read port follows the captured snoop address, never the live bus.
  assign snp_idx = addr_r[3 +: $clog2(SETS)];

  // Gather per-way frame fields and pick the hit way; lowest way wins a double hit.
  always_comb begin
    hit_s = 1'b0;
    way_s = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      frame_s[w] = {frame_valid[w], frame_dirty[w], frame_tag[w], frame_data[w]};
      if (frame_s[w].valid && (frame_s[w].tag == addr_r[31:6])) begin
        hit_s = 1'b1;
        way_s = 1'(w);
      end else begin
        hit_s = hit_s;
        way_s = way_s;
      end
    end
    hit_frame_s = frame_s[way_s];
    hitdirty_s  = hit_s & hit_frame_s.dirty;
  end

  // Snoop FSM and captured snoop fields; a dropped ccwait abandons an unfinished snoop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r    <= SNP_IDLE;
      addr_r     <= 32'h0000_0000;
      inv_r      <= 1'b0;
      hit_r      <= 1'b0;
      way_r      <= 1'b0;
      hitdirty_r <= 1'b0;
      lr_hit_r   <= 1'b0;
      word0_r    <= 32'h0000_0000;
      word1_r    <= 32'h0000_0000;
    end else begin
      case (state_r)
        SNP_IDLE: begin
          if (ccwait) begin
            addr_r   <= ccsnoopaddr & 32'hFFFF_FFF8;
            inv_r    <= ccinv;
            lr_hit_r <= 1'b0;
            state_r  <= SNP_LOOKUP;
          end else begin
            state_r <= SNP_IDLE;
          end
        end
        SNP_LOOKUP: begin
          if (!ccwait) begin
            state_r <= SNP_IDLE;
          end else begin
            hit_r      <= hit_s;
            way_r      <= way_s;
            hitdirty_r <= hitdirty_s;
            word0_r    <= hit_frame_s.data[0];
            word1_r    <= hit_frame_s.data[1];
            lr_hit_r   <= inv_r & lr_match(lr, addr_r);
            state_r    <= hitdirty_s ? SNP_WB1 : SNP_RESP;
          end
        end
        SNP_WB1: begin
          if (!ccwait) begin
            state_r <= SNP_IDLE;
          end else if (!dwait) begin
            state_r <= SNP_WB2;
          end else begin
            state_r <= SNP_WB1;
          end
        end
        SNP_WB2: begin
          if (!ccwait) begin
            state_r <= SNP_IDLE;
          end else if (!dwait) begin
            // Re-sample the link so the clear reflects lr as of the response.
            lr_hit_r <= inv_r & lr_match(lr, addr_r);
            state_r  <= SNP_RESP;
          end else begin
            state_r <= SNP_WB2;
          end
        end
        SNP_RESP: begin
          state_r <= SNP_HOLD;
        end
        SNP_HOLD: begin
          if (!ccwait) begin
            state_r <= SNP_IDLE;
          end else begin
            state_r <= SNP_HOLD;
          end
        end
        default: begin
          state_r <= SNP_IDLE;
        end
      endcase
    end
  end

  // Moore output decode from the state register and captured fields only.
  always_comb begin
    snp_busy      = (state_r != SNP_IDLE);
    ccwrite       = 1'b0;
    cctrans       = 1'b0;
    snp_dWEN      = 1'b0;
    snp_daddr     = 32'h0000_0000;
    snp_dstore    = 32'h0000_0000;
    snp_upd       = 1'b0;
    snp_upd_way   = 1'b0;
    snp_upd_valid = 1'b0;
    snp_upd_dirty = 1'b0;
    lr_clear      = 1'b0;
    case (state_r)
      SNP_WB1: begin
        ccwrite    = hitdirty_r;
        snp_dWEN   = 1'b1;
        snp_daddr  = addr_r;
        snp_dstore = word0_r;
      end
      SNP_WB2: begin
        ccwrite    = hitdirty_r;
        snp_dWEN   = 1'b1;
        snp_daddr  = addr_r + 32'd4;
        snp_dstore = word1_r;
      end
      SNP_RESP: begin
        ccwrite  = hitdirty_r;
        cctrans  = 1'b1;
        lr_clear = lr_hit_r;
        if (hit_r) begin
          snp_upd       = 1'b1;
          snp_upd_way   = way_r;
          snp_upd_valid = ~inv_r;
        end else begin
          snp_upd       = 1'b0;
        end
      end
      default: begin
        ccwrite = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_snoop_responder.sv
// Bench for dcache_snoop_responder: directed scenarios plus random snoops,
// each checked cycle by cycle against a timeline built from the snoop rules.
module tb_dcache_snoop_responder;
  import custom_types_pkg::*;

  logic                 CLK;
  logic                 RST;
  logic                 ccwait;
  logic                 ccinv;
  logic [31:0]          ccsnoopaddr;
  logic                 dwait;
  logic [1:0]           frame_valid;
  logic [1:0]           frame_dirty;
  logic [1:0][25:0]     frame_tag;
  logic [1:0][1:0][31:0] frame_data;
  lr_t                  lr;
  logic [2:0]           snp_idx;
  logic                 snp_busy, ccwrite, cctrans, snp_dWEN;
  logic [31:0]          snp_daddr, snp_dstore;
  logic                 snp_upd, snp_upd_way, snp_upd_valid, snp_upd_dirty, lr_clear;

  // Dcache contents seen by the responder.
  logic        fv   [8][2];
  logic        fdty [8][2];
  logic [25:0] ftag [8][2];
  logic [31:0] fdat [8][2][2];

  int tests = 0;
  int fails = 0;

  dcache_snoop_responder #(.SETS(8), .WAYS(2)) dut (
    .CLK(CLK), .RST(RST), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .dwait(dwait), .frame_valid(frame_valid), .frame_dirty(frame_dirty),
    .frame_tag(frame_tag), .frame_data(frame_data), .lr(lr), .snp_idx(snp_idx),
    .snp_busy(snp_busy), .ccwrite(ccwrite), .cctrans(cctrans), .snp_dWEN(snp_dWEN),
    .snp_daddr(snp_daddr), .snp_dstore(snp_dstore), .snp_upd(snp_upd),
    .snp_upd_way(snp_upd_way), .snp_upd_valid(snp_upd_valid),
    .snp_upd_dirty(snp_upd_dirty), .lr_clear(lr_clear)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // The dcache read port: present the frames of the set the responder asks for.
  always_comb begin
    for (int w = 0; w < 2; w++) begin
      frame_valid[w]   = fv[snp_idx][w];
      frame_dirty[w]   = fdty[snp_idx][w];
      frame_tag[w]     = ftag[snp_idx][w];
      frame_data[w][0] = fdat[snp_idx][w][0];
      frame_data[w][1] = fdat[snp_idx][w][1];
    end
  end

  function automatic logic [72:0] ev(input logic busy, input logic ccw, input logic cct,
                                     input logic wen, input logic [31:0] da, input logic [31:0] ds,
                                     input logic upd, input logic uw, input logic uv,
                                     input logic ud, input logic lrc);
    return {busy, ccw, cct, wen, da, ds, upd, uw, uv, ud, lrc};
  endfunction

  function automatic logic [72:0] obs_now();
    return {snp_busy, ccwrite, cctrans, snp_dWEN, snp_daddr, snp_dstore,
            snp_upd, snp_upd_way, snp_upd_valid, snp_upd_dirty, lr_clear};
  endfunction

  task automatic check(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One snoop: abort_at is the cycle whose end drops ccwait (ignored if not before the response).
  task automatic run_snoop(input string tag, input logic [31:0] a, input logic inv,
                           input int d0, input int d1, input int abort_at);
    logic [25:0] t;
    int          idx;
    logic        hit;
    logic        w;
    logic        dirty;
    logic        lrc;
    logic [31:0] base;
    int          resp_c;
    logic [72:0] exp;
    t    = a[31:6];
    idx  = int'(a[5:3]);
    base = {a[31:3], 3'b000};
    hit  = 1'b0;
    w    = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (!hit && fv[idx][k] && (ftag[idx][k] == t)) begin
        hit = 1'b1;
        w   = 1'(k);
      end
    end
    dirty  = hit && fdty[idx][w];
    lrc    = inv && lr.valid && (lr.addr[31:3] == base[31:3]);
    resp_c = dirty ? (2 + (d0 + 1) + (d1 + 1)) : 2;

    @(negedge CLK);
    check({tag, "_c0"}, obs_now(), 73'd0);
    ccsnoopaddr = a;
    ccinv       = inv;
    ccwait      = 1'b1;
    dwait       = 1'b1;
    for (int c = 1; c <= resp_c + 2; c++) begin
      @(negedge CLK);
      if (c == 1) begin
        exp = ev(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check($sformatf("%s_idx", tag), {70'd0, snp_idx}, {70'd0, a[5:3]});
        dwait = 1'b1;
      end else if (c < resp_c) begin
        if (c <= d0 + 2) begin
          exp   = ev(1'b1, 1'b1, 1'b0, 1'b1, base, fdat[idx][w][0], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
          dwait = (c == d0 + 2) ? 1'b0 : 1'b1;
        end else begin
          exp   = ev(1'b1, 1'b1, 1'b0, 1'b1, base + 32'd4, fdat[idx][w][1], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
          dwait = (c == resp_c - 1) ? 1'b0 : 1'b1;
        end
      end else if (c == resp_c) begin
        exp   = ev(1'b1, dirty, 1'b1, 1'b0, 32'd0, 32'd0, hit, hit & w, hit & ~inv, 1'b0, lrc);
        dwait = 1'b1;
      end else if (c == resp_c + 1) begin
        exp    = ev(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ccwait = 1'b0;
      end else begin
        exp = 73'd0;
      end
      check($sformatf("%s_c%0d", tag, c), obs_now(), exp);
      if ((c == abort_at) && (abort_at < resp_c)) begin
        ccwait = 1'b0;
        dwait  = 1'b1;
        @(negedge CLK);
        check($sformatf("%s_abort", tag), obs_now(), 73'd0);
        return;
      end
    end
    if (hit) begin
      fv[idx][w]   = ~inv;
      fdty[idx][w] = 1'b0;
    end
  endtask

  task automatic fill_set(input int idx);
    logic [25:0] pool [3];
    pool[0] = 26'h41;
    pool[1] = 26'h42;
    pool[2] = 26'h43;
    for (int w = 0; w < 2; w++) begin
      fv[idx][w]      = 1'($urandom_range(1, 0));
      fdty[idx][w]    = 1'($urandom_range(1, 0));
      ftag[idx][w]    = pool[$urandom_range(2, 0)];
      fdat[idx][w][0] = $urandom;
      fdat[idx][w][1] = $urandom;
    end
  endtask

  initial begin
    RST         = 1'b1;
    ccwait      = 1'b0;
    ccinv       = 1'b0;
    ccsnoopaddr = 32'd0;
    dwait       = 1'b1;
    lr          = '{addr: 32'd0, valid: 1'b0};
    for (int s = 0; s < 8; s++) begin
      for (int w = 0; w < 2; w++) begin
        fv[s][w] = 1'b0; fdty[s][w] = 1'b0; ftag[s][w] = 26'd0;
        fdat[s][w][0] = 32'd0; fdat[s][w][1] = 32'd0;
      end
    end

    // Reset state.
    @(negedge CLK);
    @(negedge CLK);
    check("reset_outs", obs_now(), 73'd0);
    check("reset_idx", {70'd0, snp_idx}, 73'd0);
    RST = 1'b0;

    // Miss: tag 0x41 absent from set 0.
    run_snoop("miss", 32'h0000_1040, 1'b0, 0, 0, -1);

    // Clean hit BusRd in way 1.
    fv[0][1] = 1'b1; fdty[0][1] = 1'b0; ftag[0][1] = 26'h41;
    run_snoop("clean_rd", 32'h0000_1040, 1'b0, 0, 0, -1);

    // Dirty hit BusRdX in way 0 (way 1 also matches: lowest way must win), 2 stall cycles per word.
    fv[0][0] = 1'b1; fdty[0][0] = 1'b1; ftag[0][0] = 26'h41;
    fdat[0][0][0] = 32'hDEAD_BEEF; fdat[0][0][1] = 32'hCAFE_F00D;
    run_snoop("dirty_rdx", 32'h0000_1040, 1'b1, 2, 2, -1);

    // LL link handling.
    lr = '{addr: 32'h0000_1044, valid: 1'b1};
    run_snoop("ll_rdx_hit", 32'h0000_1040, 1'b1, 0, 0, -1);
    run_snoop("ll_rd", 32'h0000_1040, 1'b0, 0, 0, -1);
    run_snoop("ll_rdx_other", 32'h0000_1080, 1'b1, 0, 0, -1);
    lr = '{addr: 32'd0, valid: 1'b0};

    // Abort while WB2 is stalled, then a normal snoop (low address bits must be ignored).
    fv[0][0] = 1'b1; fdty[0][0] = 1'b1; ftag[0][0] = 26'h41;
    fdat[0][0][0] = 32'h1111_2222; fdat[0][0][1] = 32'h3333_4444;
    run_snoop("abort_wb2", 32'h0000_1040, 1'b1, 0, 1, 3);
    run_snoop("after_abort", 32'h0000_1043, 1'b0, 0, 0, -1);

    // Reset mid-WB1.
    fv[0][0] = 1'b1; fdty[0][0] = 1'b1; ftag[0][0] = 26'h41;
    @(negedge CLK);
    ccsnoopaddr = 32'h0000_1040; ccinv = 1'b1; ccwait = 1'b1; dwait = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("rst_pre_wb1", obs_now(),
          ev(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_1040, 32'h1111_2222, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    RST = 1'b1;
    #1;
    check("rst_async", obs_now(), 73'd0);
    @(negedge CLK);
    RST = 1'b0; ccwait = 1'b0; ccinv = 1'b0;
    fv[0][0] = 1'b0; fv[0][1] = 1'b0;
    run_snoop("post_rst_miss", 32'h0000_1040, 1'b0, 0, 0, -1);

    // Random snoops.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      int          idx;
      idx = $urandom_range(7, 0);
      if ($urandom_range(2, 0) != 0) fill_set(idx);
      a = {26'h40 + 26'($urandom_range(3, 1)), 3'(idx), 3'($urandom_range(7, 0))};
      if ($urandom_range(1, 0) == 1)
        lr = '{addr: {26'h40 + 26'($urandom_range(3, 1)), 3'(idx), 3'($urandom_range(7, 0))},
               valid: 1'($urandom_range(1, 0))};
      run_snoop($sformatf("rnd%0d", n), a, 1'($urandom_range(1, 0)),
                $urandom_range(2, 0), $urandom_range(2, 0),
                ($urandom_range(4, 0) == 0) ? $urandom_range(6, 1) : -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
